// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared types and helpers for the nibble-serial adder.
//               - sa_state_t   : sequencer state encoding (IDLE, ADD, DONE)
//               - NIBBLE_W     : width of one datapath nibble
//               - cnt_width()  : nibble counter width, never below 1 bit
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

    // A single-nibble build still needs a 1-bit counter so the index
    // compare has something to look at.
    function automatic int cnt_width(input int nibbles);
        if (nibbles <= 2) begin
            return 1;
        end
        return $clog2(nibbles);
    endfunction

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_fourbitadder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_fourbitadder
// Description : Purely combinational 4-bit adder with carry-in / carry-out.
//               The sequencer feeds it one operand nibble per clock.
// Ports       : i_a, i_b  - 4-bit addends
//               i_carry   - carry-in
//               o_sum     - 4-bit sum
//               o_carry   - carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_fourbitadder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_carry,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_carry
);

    logic [NIBBLE_W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_carry};
    assign o_sum   = w_total[NIBBLE_W-1:0];
    assign o_carry = w_total[NIBBLE_W];

endmodule : nibble_serial_adder_fourbitadder
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Multi-precision add/subtract sequencer. Accepts two
//               NIBBLES*4-bit operands over valid/ready, walks them LSB-first
//               through one 4-bit adder (one nibble per clock, carry kept in a
//               register) and presents the registered result over valid/ready.
// Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//               i_valid / o_ready     - operand handshake (ready only in IDLE)
//               i_a, i_b              - operands
//               i_carry               - carry into nibble 0
//               i_sub                 - invert B before adding
//               o_valid / i_ready     - result handshake
//               o_sum                 - registered W-bit sum
//               o_carry               - carry-out of the top nibble
//               o_overflow            - signed overflow of the W-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [NIBBLES*4-1:0]    i_a,
    input  logic [NIBBLES*4-1:0]    i_b,
    input  logic                    i_carry,
    input  logic                    i_sub,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [NIBBLES*4-1:0]    o_sum,
    output logic                    o_carry,
    output logic                    o_overflow
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int CNT_W = cnt_width(NIBBLES);

    localparam logic [CNT_W-1:0] c_last_nib = CNT_W'(NIBBLES - 1);

    sa_state_t           r_state;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b_eff;
    logic                r_carry;
    logic [CNT_W-1:0]    r_cnt;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_carry;
    logic                w_last;

    // ------------------------------------------------------------------
    // Nibble select: pick nibble r_cnt of each latched operand.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_cnt == CNT_W'(n)) begin
                w_a_nib = r_a[n*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b_eff[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    assign w_last = (r_cnt == c_last_nib);

    nibble_serial_adder_fourbitadder u_adder (
        .i_a     (w_a_nib),
        .i_b     (w_b_nib),
        .i_carry (r_carry),
        .o_sum   (w_nib_sum),
        .o_carry (w_nib_carry)
    );

    // ------------------------------------------------------------------
    // Sequencer with registered handshake and result outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b_eff    <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_a;
                        r_b_eff <= i_sub ? ~i_b : i_b;
                        r_carry <= i_carry;
                        r_cnt   <= '0;
                        o_sum   <= '0;
                        o_ready <= 1'b0;
                        r_state <= ST_ADD;
                    end
                end

                ST_ADD: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_cnt == CNT_W'(n)) begin
                            o_sum[n*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
                        end
                    end
                    r_carry <= w_nib_carry;
                    if (w_last) begin
                        // Top nibble: sum bit 3 is the result sign bit.
                        o_carry    <= w_nib_carry;
                        o_overflow <= (r_a[W-1] == r_b_eff[W-1]) &&
                                      (w_nib_sum[NIBBLE_W-1] != r_a[W-1]);
                        o_valid    <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Handoff cycle: no new acceptance here even if i_valid
                    // is high; ready only reasserts once back in IDLE.
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : nibble_serial_adder
`default_nettype wire
